dp_shift_reg: RTL and testbench



---
 rtl/dp_shift_reg_pkg.sv | 21 ++
 rtl/dp_bit_cell.sv | 33 +++
 rtl/dp_shift_reg.sv | 109 ++++++++++
 tb/tb_dp_shift_reg.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dp_shift_reg_pkg.sv
// Shared definitions for the dp_shift_reg register stage: controller states,
// direction encodings and the per-bit shift-source helper.
package dp_shift_reg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Left shifts pull from the lower neighbour, right shifts from the upper one.
    function automatic logic pick_shift_in(input logic dir,
                                           input logic from_lower,
                                           input logic from_upper);
        return (dir == DIR_RIGHT) ? from_upper : from_lower;
    endfunction

endpackage

// File: rtl/dp_bit_cell.sv
// One register bit: 2:1 select between parallel-load and shift-in data,
// feeding a flip-flop with asynchronous active-low clear and a hold enable.
module dp_bit_cell (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic sel_i,
    input  logic load_bit_i,
    input  logic shift_bit_i,
    output logic q_o
);

    logic bit_d;
    logic bit_q;

    always_comb begin
        bit_d = bit_q;
        if (en_i) begin
            bit_d = sel_i ? load_bit_i : shift_bit_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign q_o = bit_q;

endmodule

// File: rtl/dp_shift_reg.sv
// Parallel-load bidirectional shift register with a fixed-length serial
// transfer controller (Start/Busy/Done handshake).
module dp_shift_reg
    import dp_shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Dir,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             SerIn,
    output logic [WIDTH-1:0] Q,
    output logic             SerOut,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned     CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            dir_q;
    logic            busy_q;
    logic            done_q;

    logic [WIDTH-1:0] reg_q;
    logic             load_d;
    logic             en_d;

    // Load only counts in IDLE; it also beats a simultaneous Start.
    assign load_d = (state_q == IDLE) && Load;
    assign en_d   = load_d || (state_q == SHIFT);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic from_lower;
        logic from_upper;

        if (i == 0) begin : g_lsb
            assign from_lower = SerIn;
        end else begin : g_lo
            assign from_lower = reg_q[i-1];
        end

        if (i == WIDTH - 1) begin : g_msb
            assign from_upper = SerIn;
        end else begin : g_hi
            assign from_upper = reg_q[i+1];
        end

        dp_bit_cell u_cell (
            .clk_i       (Clk),
            .rst_ni      (Reset_n),
            .en_i        (en_d),
            .sel_i       (load_d),
            .load_bit_i  (D[i]),
            .shift_bit_i (pick_shift_in(dir_q, from_lower, from_upper)),
            .q_o         (reg_q[i])
        );
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_LEFT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (Start && !Load) begin
                        dir_q   <= Dir;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Q      = reg_q;
    assign SerOut = (dir_q == DIR_RIGHT) ? reg_q[0] : reg_q[WIDTH-1];
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_dp_shift_reg.sv
// Directed bench for dp_shift_reg (WIDTH = 8): reset, load, left/right
// transfers, ignored Load/Start conflicts and a mid-transfer abort.
module tb_dp_shift_reg;

    logic       Clk;
    logic       Reset_n;
    logic       Start;
    logic       Dir;
    logic       Load;
    logic [7:0] D;
    logic       SerIn;
    logic [7:0] Q;
    logic       SerOut;
    logic       Busy;
    logic       Done;

    int unsigned checks = 0;
    int unsigned errors = 0;

    dp_shift_reg #(.WIDTH(8)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Start   (Start),
        .Dir     (Dir),
        .Load    (Load),
        .D       (D),
        .SerIn   (SerIn),
        .Q       (Q),
        .SerOut  (SerOut),
        .Busy    (Busy),
        .Done    (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    logic [7:0] exp_bits;
    logic [7:0] ser_pat;
    int unsigned busy_cycles;
    int unsigned done_seen;

    initial begin
        Reset_n = 1'b1; Start = 1'b0; Dir = 1'b0; Load = 1'b0; D = '0; SerIn = 1'b0;

        // Asynchronous reset between edges
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_q",      32'(Q),      32'h00);
        chk("rst_busy",   32'(Busy),   32'h0);
        chk("rst_done",   32'(Done),   32'h0);
        chk("rst_serout", 32'(SerOut), 32'h0);
        tick(); tick();
        Reset_n = 1'b1;
        tick();

        // Parallel load
        Load = 1'b1; D = 8'hA5;
        tick();
        Load = 1'b0;
        chk("load_q",    32'(Q),    32'hA5);
        chk("load_busy", 32'(Busy), 32'h0);
        chk("load_done", 32'(Done), 32'h0);

        // Left transfer of 0x81 with SerIn = 1
        Load = 1'b1; D = 8'h81;
        tick();
        Load = 1'b0;
        Start = 1'b1; Dir = 1'b0; SerIn = 1'b1;
        tick();
        Start = 1'b0;
        exp_bits = 8'b1000_0001;
        for (int j = 0; j < 8; j++) begin
            chk("left_busy",   32'(Busy),   32'h1);
            chk("left_serout", 32'(SerOut), 32'(exp_bits[7-j]));
            tick();
        end
        chk("left_busy_end", 32'(Busy), 32'h0);
        chk("left_done",     32'(Done), 32'h1);
        chk("left_q",        32'(Q),    32'hFF);
        tick();
        chk("left_done_fall", 32'(Done), 32'h0);
        chk("left_idle_busy", 32'(Busy), 32'h0);

        // Right transfer of 0x01 with SerIn = 0 (accepted at the earliest slot)
        Load = 1'b1; D = 8'h01;
        tick();
        Load = 1'b0;
        chk("right_load_q", 32'(Q), 32'h01);
        Start = 1'b1; Dir = 1'b1; SerIn = 1'b0;
        tick();
        Start = 1'b0;
        exp_bits = 8'b1000_0000;
        done_seen = 0;
        for (int j = 0; j < 8; j++) begin
            chk("right_serout", 32'(SerOut), 32'(exp_bits[7-j]));
            tick();
            if (Done) done_seen++;
        end
        tick();
        if (Done) done_seen++;
        chk("right_q",         32'(Q),         32'h00);
        chk("right_done_once", 32'(done_seen), 32'd1);

        // Load held through SHIFT and DONE is ignored; SerIn pattern lands in Q
        Load = 1'b1; D = 8'h96;
        tick();
        Start = 1'b1; Dir = 1'b0; Load = 1'b0;
        tick();
        Start = 1'b0;
        Load = 1'b1; D = 8'h3C;
        exp_bits = 8'b1001_0110;
        ser_pat  = 8'b1011_0010;
        for (int j = 0; j < 8; j++) begin
            SerIn = ser_pat[7-j];
            chk("conf_serout", 32'(SerOut), 32'(exp_bits[7-j]));
            tick();
        end
        chk("conf_done", 32'(Done), 32'h1);
        chk("conf_q",    32'(Q),    32'hB2);
        tick();
        chk("conf_q_idle", 32'(Q), 32'hB2);
        Load = 1'b0;

        // Start together with Load in IDLE: Load wins, Start dropped
        Start = 1'b1; Load = 1'b1; D = 8'h5A;
        tick();
        Start = 1'b0; Load = 1'b0;
        chk("both_q",    32'(Q),    32'h5A);
        chk("both_busy", 32'(Busy), 32'h0);
        tick();
        chk("both_busy2", 32'(Busy), 32'h0);
        chk("both_done2", 32'(Done), 32'h0);

        // Abort after three shifts
        Start = 1'b1; Dir = 1'b0; SerIn = 1'b1;
        tick();
        Start = 1'b0;
        tick(); tick(); tick();
        chk("abort_pre_q", 32'(Q), 32'hD7);
        #3 Reset_n = 1'b0;
        #1;
        chk("abort_q",      32'(Q),      32'h00);
        chk("abort_busy",   32'(Busy),   32'h0);
        chk("abort_done",   32'(Done),   32'h0);
        chk("abort_serout", 32'(SerOut), 32'h0);
        tick();
        Reset_n = 1'b1;
        done_seen = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (Done) done_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);

        // Full right transfer after abort; Dir input changes after Start
        Start = 1'b1; Dir = 1'b1; SerIn = 1'b1;
        tick();
        Start = 1'b0; Dir = 1'b0;
        tick(); tick(); tick();
        chk("post_q_3shift", 32'(Q), 32'hE0);
        busy_cycles = 1;
        done_seen   = 0;
        for (int j = 0; j < 20 && done_seen == 0; j++) begin
            if (Busy) busy_cycles++;
            tick();
            if (Done) done_seen++;
        end
        chk("post_done",  32'(done_seen),   32'd1);
        chk("post_busy",  32'(busy_cycles), 32'd6);
        chk("post_q",     32'(Q),           32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
